rvee_pcgen: RTL and testbench

//   Program-counter generator; drives the pcgen side of rvee_pcgen_if.
//   - Offers sequential fetch addresses to the fetch stage with a valid/ready handshake.
//   - Takes jump and conditional-branch requests from exec.
//   - Redirects the PC and flags the redirect to fetch and decode so they can squash wrong-path work.

---
 rtl/rvee_pcgen.sv | 100 ++++++++++
 tb/tb_rvee_pcgen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rvee_pcgen.sv
// Program-counter generator: sequential fetch addresses with a valid/ready handshake,
// plus jump and one-cycle-delayed conditional-branch redirects from exec.
module rvee_pcgen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              INSN_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ready,
  input  logic            ready_ff,
  input  logic            jmp,
  input  logic            bcc,
  input  logic [XLEN-1:0] jmp_base,
  input  logic [XLEN-1:0] jmp_offset,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_ff,
  output logic            jmp_ff,
  output logic            jmp_out
);

  typedef enum logic [1:0] {
    S_RST,
    S_RUN,
    S_BCC
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] btgt;
  logic            transfer;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            latch_btgt;

  // Bit 0 is cleared as for RISC-V JALR; any other misalignment is left for exec to trap.
  assign tgt      = (jmp_base + jmp_offset) & ~XLEN'(1);
  assign valid    = (state != S_RST);
  assign transfer = valid & ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next  = state;
    redirect    = 1'b0;
    redirect_pc = tgt;
    latch_btgt  = 1'b0;
    case (state)
      S_RST: state_next = S_RUN;
      S_RUN: begin
        if (jmp) begin
          redirect = 1'b1;
        end else if (bcc) begin
          latch_btgt = 1'b1;
          state_next = S_BCC;
        end
      end
      S_BCC: begin
        state_next  = S_RUN;
        redirect    = jmp;
        redirect_pc = btgt;
      end
      default: state_next = S_RST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RST;
      pc      <= RESET_PC;
      pc_ff   <= RESET_PC;
      btgt    <= '0;
      jmp_ff  <= 1'b0;
      jmp_out <= 1'b0;
    end else begin
      state  <= state_next;
      jmp_ff <= redirect;

      if (redirect)      pc <= redirect_pc;
      else if (transfer) pc <= pc + XLEN'(INSN_BYTES);

      // Only an accepted fetch moves pc_ff; a registered-idle fetch stage keeps it put.
      if (transfer)       pc_ff <= pc;
      else if (!ready_ff) pc_ff <= pc_ff;

      if (latch_btgt) btgt <= tgt;

      if (redirect)      jmp_out <= 1'b1;
      else if (transfer) jmp_out <= 1'b0;
    end
  end

  // A second bcc before the first resolves has no defined meaning; it is ignored above.
  bcc_while_pending : assert property (@(posedge clk) disable iff (rst) !(state == S_BCC && bcc))
    else $error("rvee_pcgen: bcc asserted while a branch is pending");

endmodule

// File: tb/tb_rvee_pcgen.sv
// Self-checking bench for rvee_pcgen: a hand-derived vector table driven cycle by cycle,
// with expected outputs queued at drive time and compared after the clock edge.
module tb_rvee_pcgen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        ready_ff = 1'b0;
  logic        jmp = 1'b0;
  logic        bcc = 1'b0;
  logic [31:0] jmp_base = '0;
  logic [31:0] jmp_offset = '0;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] pc_ff;
  logic        jmp_ff;
  logic        jmp_out;

  int checks = 0;
  int errors = 0;

  rvee_pcgen #(.XLEN(32), .RESET_PC(32'h0), .INSN_BYTES(4)) dut (
    .clk(clk),
    .rst(rst),
    .ready(ready),
    .ready_ff(ready_ff),
    .jmp(jmp),
    .bcc(bcc),
    .jmp_base(jmp_base),
    .jmp_offset(jmp_offset),
    .valid(valid),
    .pc(pc),
    .pc_ff(pc_ff),
    .jmp_ff(jmp_ff),
    .jmp_out(jmp_out)
  );

  always #5 clk = ~clk;

  // Fetch-side registered ready.
  always @(posedge clk) ready_ff <= ready;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_ff;
    logic        jmp_ff;
    logic        jmp_out;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        jmp;
    logic        bcc;
    logic [31:0] base;
    logic [31:0] offset;
    exp_t        exp;
  } vec_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic r, input logic rd, input logic j, input logic b,
                              input logic [31:0] base, input logic [31:0] off,
                              input logic ev, input logic [31:0] epc, input logic [31:0] epcff,
                              input logic ejff, input logic ejout);
    vec_t v;
    v.rst = r; v.ready = rd; v.jmp = j; v.bcc = b; v.base = base; v.offset = off;
    v.exp.valid = ev; v.exp.pc = epc; v.exp.pc_ff = epcff;
    v.exp.jmp_ff = ejff; v.exp.jmp_out = ejout;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  task automatic step(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; ready = v.ready; jmp = v.jmp; bcc = v.bcc;
    jmp_base = v.base; jmp_offset = v.offset;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check($sformatf("v%0d scoreboard_empty", idx), 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("v%0d valid", idx),   {31'd0, valid},   {31'd0, e.valid});
      check($sformatf("v%0d pc", idx),      pc,               e.pc);
      check($sformatf("v%0d pc_ff", idx),   pc_ff,            e.pc_ff);
      check($sformatf("v%0d jmp_ff", idx),  {31'd0, jmp_ff},  {31'd0, e.jmp_ff});
      check($sformatf("v%0d jmp_out", idx), {31'd0, jmp_out}, {31'd0, e.jmp_out});
    end
  endtask

  initial begin
    //                rst rdy jmp bcc base          offset          valid pc            pc_ff         jff jout
    // Reset held three cycles, then sequential fetch
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,         32'h0,          0, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,         32'h0,          0, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,         32'h0,          0, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h4,         32'h0,         0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h8,         32'h4,         0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'hC,         32'h8,         0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h10,        32'hC,         0, 0));
    // Stall four cycles at 0x10
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h10,        32'hC,         0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h10,        32'hC,         0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h10,        32'hC,         0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h10,        32'hC,         0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h14,        32'h10,        0, 0));
    // Jump to 0x121 (bit 0 cleared) under stall; jmp_out held until accept
    vecs.push_back(mk(0, 0, 1, 0, 32'h100,       32'h21,         1, 32'h120,       32'h10,        1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h120,       32'h10,        0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h120,       32'h10,        0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h124,       32'h120,       0, 0));
    // Branch taken: target 0x1F8 latched with bcc; operands during resolution are ignored
    vecs.push_back(mk(0, 1, 0, 1, 32'h200,       32'hFFFF_FFF8,  1, 32'h128,       32'h124,       0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h40,        32'h40,         1, 32'h1F8,       32'h128,       1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h1FC,       32'h1F8,       0, 0));
    // Branch not taken
    vecs.push_back(mk(0, 1, 0, 1, 32'h300,       32'hFFFF_FFF8,  1, 32'h200,       32'h1FC,       0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h204,       32'h200,       0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h208,       32'h204,       0, 0));
    // Reset in the resolution cycle of a taken branch; nothing redirects after release
    vecs.push_back(mk(0, 1, 0, 1, 32'h300,       32'hFFFF_FFF8,  1, 32'h20C,       32'h208,       0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,         32'h0,          0, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h4,         32'h0,         0, 0));
    // bcc+jmp acts as a jump; back-to-back redirect while jmp_out is set
    vecs.push_back(mk(0, 0, 1, 1, 32'h1000,      32'h10,         1, 32'h1010,      32'h0,         1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 32'h2000,      32'h3,          1, 32'h2002,      32'h0,         1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h2006,      32'h2002,      0, 0));
    // Jump coinciding with a transfer, then wrap-around past 0xFFFFFFFC
    vecs.push_back(mk(0, 1, 1, 0, 32'hFFFF_FFF0, 32'hC,          1, 32'hFFFF_FFFC, 32'h2006,      1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h0,         32'hFFFF_FFFC, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h4,         32'h0,         0, 0));
    // Target addition wraps modulo 2^32
    vecs.push_back(mk(0, 0, 1, 0, 32'hFFFF_FFF0, 32'h20,         1, 32'h10,        32'h0,         1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h10,        32'h0,         0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0,          1, 32'h14,        32'h10,        0, 0));

    for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
